// File: rtl/data_receiver.sv
`default_nettype none
// ============================================================================
// Module   : data_receiver
// Purpose  : Receives a framed serial word. transmission marks the frame,
//            clock is the serial bit clock and data the serial bit (MSB
//            first). All three lines are asynchronous and are synchronized
//            into clk before use. A frame of exactly WIDTH bits updates
//            out_data and pulses valid; any other length, or a stalled serial
//            clock, pulses error.
// Ports    : clk          - system clock, rising edge active
//            rst          - asynchronous active-low reset
//            transmission - frame-active line (async)
//            clock        - serial bit clock (async)
//            data         - serial data line (async)
//            out_data     - last correctly received word
//            valid        - one-cycle pulse when out_data updates
//            busy         - high while a frame is in progress
//            error        - one-cycle pulse when a frame is rejected
// Revision : 1.0 - initial release
// ============================================================================
module data_receiver #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             transmission,
  input  logic             clock,
  input  logic             data,
  output logic [WIDTH-1:0] out_data,
  output logic             valid,
  output logic             busy,
  output logic             error
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECEIVE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam logic [CW-1:0] C_CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

  // Synchronizer chains plus one history flop for edge detection
  logic r_trans_s1, r_trans_s2, r_trans_d;
  logic r_sclk_s1,  r_sclk_s2,  r_sclk_d;
  logic r_data_s1,  r_data_s2;

  // Counts the first clk edges after reset release. Until the synchronizer
  // and history flops all hold real samples, a transmission line that was
  // already high would look like a rising edge, so edges are ignored.
  logic [1:0] r_warm;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_out_data;
  logic             r_valid;
  logic             r_error;

  logic w_trans_rise;
  logic w_trans_fall;
  logic w_sclk_rise;

  assign w_trans_rise = (r_warm == 2'd3) &  r_trans_s2 & ~r_trans_d;
  assign w_trans_fall = (r_warm == 2'd3) & ~r_trans_s2 &  r_trans_d;
  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trans_s1 <= 1'b0;
      r_trans_s2 <= 1'b0;
      r_trans_d  <= 1'b0;
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_data_s1  <= 1'b0;
      r_data_s2  <= 1'b0;
      r_warm     <= 2'd0;
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_timer    <= '0;
      r_out_data <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_trans_s1 <= transmission;
      r_trans_s2 <= r_trans_s1;
      r_trans_d  <= r_trans_s2;
      r_sclk_s1  <= clock;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_d   <= r_sclk_s2;
      r_data_s1  <= data;
      r_data_s2  <= r_data_s1;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end

      r_valid <= 1'b0;
      r_error <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A serial edge coinciding with the frame start is dropped
          if (w_trans_rise) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_state   <= S_RECEIVE;
          end
        end

        S_RECEIVE: begin
          // The frame end wins over a serial edge in the same cycle, so
          // that edge is never counted
          if (w_trans_fall) begin
            if (r_bit_cnt == C_CNT_FULL) begin
              r_out_data <= r_shift;
              r_valid    <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[WIDTH-2:0], r_data_s2};
            // Saturating one past full keeps "overlong" sticky
            if (r_bit_cnt != C_CNT_SAT) begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            r_timer <= '0;
          end else if (r_timer == C_TMO_LAST) begin
            r_error <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_DRAIN: begin
          if (w_trans_fall) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_data = r_out_data;
  assign valid    = r_valid;
  assign error    = r_error;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_receiver
// Purpose  : Self-checking bench for data_receiver. Stimulus pushes the
//            expected pulse (valid + word, or error) onto a scoreboard queue;
//            a monitor pops and compares whenever valid or error is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_receiver;

  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 1024;

  logic             clk;
  logic             rst;
  logic             transmission;
  logic             clock;
  logic             data;
  logic [WIDTH-1:0] out_data;
  logic             valid;
  logic             busy;
  logic             error;

  data_receiver #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .transmission (transmission),
    .clock        (clock),
    .data         (data),
    .out_data     (out_data),
    .valid        (valid),
    .busy         (busy),
    .error        (error)
  );

  typedef struct {
    bit               is_valid;
    logic [WIDTH-1:0] word;
  } exp_t;

  exp_t             sb_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  int               last_err_cyc = -1;
  logic [WIDTH-1:0] exp_out = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && (valid || error)) begin
      chk("valid_error_exclusive", WIDTH'(valid & error), '0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b expected none",
                 valid, error);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_kind_valid", WIDTH'(valid), WIDTH'(e.is_valid));
        if (valid && e.is_valid) chk("pulse_word", out_data, e.word);
      end
      if (error) last_err_cyc = cyc;
    end
  end

  // Sends nbits serial bits: the first min(nbits,WIDTH) taken MSB-first from
  // word, any extra bits random. Expectation derives only from the length.
  task automatic send_frame(input logic [WIDTH-1:0] word, input int nbits,
                            input int gap, input bit edge_at_fall);
    exp_t e;
    e.is_valid = (nbits == WIDTH);
    e.word     = word;
    sb_q.push_back(e);
    if (nbits == WIDTH) exp_out = word;

    transmission = 1'b1;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < WIDTH) data = word[WIDTH-1-i];
      else           data = 1'($urandom);
      wait_clk(4);
      clock = 1'b1;
      wait_clk(4);
      clock = 1'b0;
      if (i == 0) chk("busy_in_frame", WIDTH'(busy), WIDTH'(1));
    end
    wait_clk(4);
    if (edge_at_fall) begin
      data         = ~data;
      clock        = 1'b1;
      transmission = 1'b0;
      wait_clk(1);
      clock = 1'b0;
      wait_clk(gap);
    end else begin
      transmission = 1'b0;
      wait_clk(gap);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int               t_edge;
    int               lat;

    rst          = 1'b0;
    transmission = 1'b0;
    clock        = 1'b0;
    data         = 1'b0;
    wait_clk(5);
    chk("reset_out_data", out_data, '0);
    chk("reset_valid", WIDTH'(valid), '0);
    chk("reset_busy", WIDTH'(busy), '0);
    chk("reset_error", WIDTH'(error), '0);
    rst = 1'b1;
    wait_clk(5);

    // Known word
    send_frame(64'hDEADBEEF01234567, 64, 4, 1'b0);
    wait_clk(6);
    chk("known_word_out", out_data, exp_out);
    chk("idle_after_frame", WIDTH'(busy), '0);

    // Short then long frames are rejected, output held
    send_frame({$urandom, $urandom}, 63, 4, 1'b0);
    send_frame({$urandom, $urandom}, 65, 4, 1'b0);
    wait_clk(6);
    chk("held_after_errors", out_data, exp_out);

    // Stalled serial clock
    transmission = 1'b1;
    wait_clk(4);
    t_edge = 0;
    for (int i = 0; i < 10; i++) begin
      data = 1'($urandom);
      wait_clk(4);
      clock  = 1'b1;
      t_edge = cyc;
      wait_clk(4);
      clock = 1'b0;
    end
    begin
      exp_t e;
      e.is_valid = 1'b0;
      e.word     = '0;
      sb_q.push_back(e);
    end
    last_err_cyc = -1;
    for (int i = 0; i < TIMEOUT + 100 && last_err_cyc < 0; i++) wait_clk(1);
    lat = last_err_cyc - t_edge;
    chk("timeout_latency_in_window",
        WIDTH'((last_err_cyc >= 0) && (lat >= TIMEOUT) && (lat <= TIMEOUT + 6)),
        WIDTH'(1));
    wait_clk(20);
    chk("busy_in_drain", WIDTH'(busy), WIDTH'(1));
    for (int i = 0; i < 3; i++) begin
      wait_clk(4);
      clock = 1'b1;
      wait_clk(4);
      clock = 1'b0;
    end
    chk("busy_in_drain_after_edges", WIDTH'(busy), WIDTH'(1));
    transmission = 1'b0;
    wait_clk(6);
    chk("idle_after_drain", WIDTH'(busy), '0);
    send_frame({$urandom, $urandom}, 64, 4, 1'b0);

    // Back-to-back frames with minimal gap
    send_frame(64'h1, 64, 2, 1'b0);
    send_frame(64'hFFFFFFFFFFFFFFFF, 64, 2, 1'b0);
    wait_clk(6);
    chk("back_to_back_last", out_data, exp_out);

    // Serial edge coincident with the frame end
    send_frame({$urandom, $urandom}, 64, 4, 1'b1);
    wait_clk(6);
    chk("edge_at_fall_word", out_data, exp_out);

    // Reset in the middle of a frame
    transmission = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 32; i++) begin
      data = 1'($urandom);
      wait_clk(4);
      clock = 1'b1;
      wait_clk(4);
      clock = 1'b0;
    end
    rst = 1'b0;
    #1;
    exp_out = '0;
    chk("midreset_out_data", out_data, exp_out);
    chk("midreset_busy", WIDTH'(busy), '0);
    chk("midreset_valid", WIDTH'(valid), '0);
    chk("midreset_error", WIDTH'(error), '0);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(20);
    chk("no_start_when_high_at_release", WIDTH'(busy), '0);
    transmission = 1'b0;
    wait_clk(4);
    send_frame({$urandom, $urandom}, 64, 4, 1'b0);
    wait_clk(6);
    chk("frame_after_reset", out_data, exp_out);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      int sel;
      int nb;
      sel = $urandom_range(0, 4);
      nb  = (sel == 0) ? 63 : (sel == 4) ? 65 : 64;
      w   = {$urandom, $urandom};
      send_frame(w, nb, $urandom_range(2, 6), 1'($urandom_range(0, 1)));
    end
    wait_clk(6);
    chk("random_final_out", out_data, exp_out);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) wait_clk(1);
    chk("scoreboard_drained", WIDTH'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
